// File: rtl/nv_nvdla_sdp_rdma_lat_fifo.sv
// nv_nvdla_sdp_rdma_lat_fifo: latency buffer and read-credit gate between SDP RDMA engine and DMA interface
//   eng_rd_req_*            request from RDMA engine, passed to dma_rd_req_* when a buffer credit is free
//   dma_rd_rsp_*            read response from DMA interface into the flop FIFO (rdy = !full)
//   unp_rd_rsp_*            buffered response to the unpacker
//   dma_rd_cdt_lat_fifo_pop registered one-cycle pulse per drained entry
//   lat_cdt_cnt/lat_idle    outstanding+buffered entry count and idle status
//   lat_ovf_err             sticky: response seen while buffer full (response dropped)
module nv_nvdla_sdp_rdma_lat_fifo #(
  parameter int LAT_DEPTH = 16,
  parameter int REQ_W = 79,
  parameter int RSP_W = 257
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic [REQ_W-1:0]            eng_rd_req_pd,
  input  logic                        eng_rd_req_vld,
  output logic                        eng_rd_req_rdy,
  output logic [REQ_W-1:0]            dma_rd_req_pd,
  output logic                        dma_rd_req_vld,
  input  logic                        dma_rd_req_rdy,
  input  logic [RSP_W-1:0]            dma_rd_rsp_pd,
  input  logic                        dma_rd_rsp_vld,
  output logic                        dma_rd_rsp_rdy,
  output logic [RSP_W-1:0]            unp_rd_rsp_pd,
  output logic                        unp_rd_rsp_vld,
  input  logic                        unp_rd_rsp_rdy,
  output logic                        dma_rd_cdt_lat_fifo_pop,
  output logic [$clog2(LAT_DEPTH):0]  lat_cdt_cnt,
  output logic                        lat_idle,
  output logic                        lat_ovf_err
);
  localparam int AW = $clog2(LAT_DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0] wr_ptr, rd_ptr, cnt;
  logic [RSP_W-1:0] mem [LAT_DEPTH];
  logic credit_ok, req_acc, wr_acc, pop_acc, full, empty;
  // cnt never exceeds LAT_DEPTH (a power of 2), so its MSB alone marks "no credit left"
  assign credit_ok = ~cnt[AW];
  assign dma_rd_req_pd = eng_rd_req_pd;
  assign dma_rd_req_vld = eng_rd_req_vld & credit_ok;
  assign eng_rd_req_rdy = dma_rd_req_rdy & credit_ok;
  assign req_acc = dma_rd_req_vld & dma_rd_req_rdy;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dma_rd_rsp_rdy = ~full;
  assign wr_acc = dma_rd_rsp_vld & ~full;
  assign unp_rd_rsp_vld = ~empty;
  assign pop_acc = ~empty & unp_rd_rsp_rdy;
  assign unp_rd_rsp_pd = mem[rd_ptr[AW-1:0]];
  assign lat_cdt_cnt = cnt;
  assign lat_idle = (cnt == '0) & empty;
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst)
    if (nvdla_core_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      dma_rd_cdt_lat_fifo_pop <= 1'b0;
      lat_ovf_err <= 1'b0;
    end else begin
      wr_ptr <= wr_acc ? wr_ptr + ONE : wr_ptr;
      rd_ptr <= pop_acc ? rd_ptr + ONE : rd_ptr;
      cnt <= cnt + (req_acc ? ONE : '0) - (pop_acc ? ONE : '0);
      dma_rd_cdt_lat_fifo_pop <= pop_acc;
      lat_ovf_err <= lat_ovf_err | (dma_rd_rsp_vld & full);
    end
  always_ff @(posedge nvdla_core_clk)
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= dma_rd_rsp_pd;
endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_lat_fifo.sv
// tb_nv_nvdla_sdp_rdma_lat_fifo: self-checking bench for the SDP RDMA latency FIFO
module tb_nv_nvdla_sdp_rdma_lat_fifo;
  localparam int D = 16, REQ_W = 79, RSP_W = 257;
  logic clk = 1'b0, rst = 1'b1;
  logic [REQ_W-1:0] eng_pd = '0, dma_req_pd;
  logic eng_vld = 1'b0, eng_rdy, dma_req_vld, dma_rdy = 1'b0;
  logic [RSP_W-1:0] rsp_pd = '0, unp_pd;
  logic rsp_vld = 1'b0, rsp_rdy, unp_vld, unp_rdy = 1'b0, cdt_pop, idle, ovf;
  logic [$clog2(D):0] cnt;

  nv_nvdla_sdp_rdma_lat_fifo #(.LAT_DEPTH(D), .REQ_W(REQ_W), .RSP_W(RSP_W)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .eng_rd_req_pd(eng_pd), .eng_rd_req_vld(eng_vld), .eng_rd_req_rdy(eng_rdy),
    .dma_rd_req_pd(dma_req_pd), .dma_rd_req_vld(dma_req_vld), .dma_rd_req_rdy(dma_rdy),
    .dma_rd_rsp_pd(rsp_pd), .dma_rd_rsp_vld(rsp_vld), .dma_rd_rsp_rdy(rsp_rdy),
    .unp_rd_rsp_pd(unp_pd), .unp_rd_rsp_vld(unp_vld), .unp_rd_rsp_rdy(unp_rdy),
    .dma_rd_cdt_lat_fifo_pop(cdt_pop), .lat_cdt_cnt(cnt), .lat_idle(idle), .lat_ovf_err(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit eng, dma, rsp, unp;
    int n, cnt_end, occ_end;
  } vec_t;

  int total = 0, bad = 0;
  int exp_cnt = 0, acc_reqs = 0, pulses = 0, rsp_id = 0;
  bit exp_pop = 0, exp_ovf = 0;
  logic [RSP_W-1:0] sb[$];

  task automatic chk(string name, logic [RSP_W-1:0] act, logic [RSP_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RSP_W-1:0] mkpd(int id);
    return {1'b1, {8{32'h9E37_0000 + id}}};
  endfunction

  // one clock: check outputs against the model, advance the model, then step past the edge
  task automatic cyc();
    bit req, pop, wr;
    #1;
    chk("req_vld", dma_req_vld, eng_vld && exp_cnt < D);
    chk("eng_rdy", eng_rdy, dma_rdy && exp_cnt < D);
    chk("req_pd", dma_req_pd, eng_pd);
    chk("rsp_rdy", rsp_rdy, sb.size() < D);
    chk("unp_vld", unp_vld, sb.size() != 0);
    chk("cnt", cnt, exp_cnt);
    chk("idle", idle, exp_cnt == 0 && sb.size() == 0);
    chk("ovf", ovf, exp_ovf);
    chk("cdt_pop", cdt_pop, exp_pop);
    pulses += int'(cdt_pop);
    req = eng_vld && dma_rdy && exp_cnt < D;
    pop = sb.size() != 0 && unp_rdy;
    wr = rsp_vld && sb.size() < D;
    if (rsp_vld && !wr) exp_ovf = 1;
    if (pop) begin
      chk("unp_pd", unp_pd, sb[0]);
      void'(sb.pop_front());
    end
    if (wr) sb.push_back(rsp_pd);
    exp_cnt += int'(req) - int'(pop);
    acc_reqs += int'(req);
    exp_pop = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic run_phase(string name, vec_t v);
    eng_vld = v.eng; dma_rdy = v.dma; rsp_vld = v.rsp; unp_rdy = v.unp;
    pulses = 0;
    for (int c = 0; c < v.n; c++) begin
      eng_pd = REQ_W'(c * 7 + 3);
      if (v.rsp) rsp_pd = mkpd(rsp_id++);
      cyc();
    end
    eng_vld = 0; rsp_vld = 0; unp_rdy = 0;
    #1;
    chk({name, "_cnt_end"}, cnt, v.cnt_end);
    chk({name, "_occ_end"}, unp_vld, v.occ_end != 0);
  endtask

  task automatic do_reset();
    eng_vld = 0; rsp_vld = 0; unp_rdy = 0;
    rst = 1;
    #2;
    chk("rst_unp_vld", unp_vld, 1'b0);
    chk("rst_req_vld", dma_req_vld, 1'b0);
    chk("rst_cnt", cnt, '0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_pop", cdt_pop, 1'b0);
    chk("rst_rsp_rdy", rsp_rdy, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_pop", cdt_pop, 1'b0);
    chk("rst_held_vld", unp_vld, 1'b0);
    rst = 0;
    sb.delete();
    exp_cnt = 0; exp_pop = 0; exp_ovf = 0; acc_reqs = 0;
  endtask

  vec_t tbl[8];

  initial begin
    tbl = '{
      '{1, 1, 0, 0, 20, 16, 0},
      '{0, 1, 1, 0, 16, 16, 16},
      '{0, 1, 0, 1, 17, 0, 0},
      '{1, 1, 0, 0, 16, 16, 0},
      '{0, 1, 1, 0, 16, 16, 16},
      '{1, 1, 0, 1, 17, 16, 0},
      '{0, 1, 1, 0, 16, 16, 16},
      '{0, 1, 0, 1, 17, 0, 0}
    };
    @(posedge clk);
    #1;
    chk("init_eng_rdy", eng_rdy, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_phase($sformatf("ph%0d", i), tbl[i]);
      if (i == 0) chk("t1_reqs_accepted", acc_reqs, 16);
      if (i == 2) begin
        chk("t2_pop_pulses", pulses, 16);
        chk("t2_idle", idle, 1'b1);
      end
    end
    chk("t3_all_drained", sb.size(), 0);

    // single response into an empty buffer becomes visible one cycle later
    do_reset();
    eng_vld = 1; dma_rdy = 1;
    cyc();
    eng_vld = 0; rsp_vld = 1; rsp_pd = 257'h1A5;
    #1;
    chk("t4_vld_same_cycle", unp_vld, 1'b0);
    cyc();
    rsp_vld = 0;
    #1;
    chk("t4_vld_next", unp_vld, 1'b1);
    chk("t4_pd_next", unp_pd, 257'h1A5);
    unp_rdy = 1;
    cyc();
    unp_rdy = 0;
    cyc();
    cyc();
    chk("t4_idle", idle, 1'b1);

    // response while full: sticky error, data dropped, contents intact
    do_reset();
    run_phase("t5_fill_req", '{1, 1, 0, 0, 20, 16, 0});
    run_phase("t5_fill_rsp", '{0, 1, 1, 0, 16, 16, 16});
    rsp_vld = 1; rsp_pd = {RSP_W{1'b1}};
    cyc();
    rsp_vld = 0;
    cyc();
    chk("t5_ovf_set", ovf, 1'b1);
    run_phase("t5_drain", '{0, 1, 0, 1, 17, 0, 0});
    chk("t5_ovf_sticky", ovf, 1'b1);

    // reset with 5 buffered and 3 outstanding discards everything
    do_reset();
    run_phase("t6_req", '{1, 1, 0, 0, 8, 8, 0});
    run_phase("t6_rsp", '{0, 1, 1, 0, 5, 8, 5});
    do_reset();
    unp_rdy = 1;
    repeat (4) cyc();
    chk("t6_idle_after", idle, 1'b1);
    chk("t6_cnt_after", cnt, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
